// File: rtl/typedefs_pkg.sv
// Shared types and helpers for the LED sequencer: FSM state encoding and the
// defeat flash pattern generator.
package typedefs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW_ON,
    ST_SHOW_GAP,
    ST_FLASH_ON,
    ST_FLASH_OFF
  } led_seq_state_t;

  localparam int MAX_LED_WIDTH = 64;

  // Alternating pattern with bit0 lit; callers truncate to their LED width.
  function automatic logic [MAX_LED_WIDTH-1:0] defeat_pattern(input int width);
    logic [MAX_LED_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_LED_WIDTH; i++) begin
      if ((i < width) && ((i % 2) == 0)) p[i] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counting phase timer: load N-1 on phase entry, zero flag marks the
// last cycle of the phase.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/led_sequencer.sv
// Shows one LED item per handshake (on-time then blank gap) and runs the
// victory/defeat flash sequences; done pulses once each operation completes.
module led_sequencer
  import typedefs_pkg::*;
#(
  parameter int DATA_WIDTH     = 4,
  parameter int ON_CYCLES_SLOW = 24_000_000,
  parameter int ON_CYCLES_FAST = 12_000_000,
  parameter int GAP_CYCLES     = 6_000_000,
  parameter int FLASH_CYCLES   = 12_000_000,
  parameter int FLASH_COUNT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  show_valid,
  output logic                  show_ready,
  input  logic [DATA_WIDTH-1:0] item,
  input  logic                  speed,
  input  logic                  flash_req,
  input  logic                  flash_win,
  output logic [DATA_WIDTH-1:0] leds,
  output logic                  busy,
  output logic                  done
);

  localparam int MAX_A   = (ON_CYCLES_SLOW > ON_CYCLES_FAST) ? ON_CYCLES_SLOW : ON_CYCLES_FAST;
  localparam int MAX_B   = (GAP_CYCLES > FLASH_CYCLES) ? GAP_CYCLES : FLASH_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int PW      = $clog2(FLASH_COUNT + 1);

  localparam logic [DATA_WIDTH-1:0] DEFEAT_LEDS = DATA_WIDTH'(defeat_pattern(DATA_WIDTH));

  // Handshake: a request is taken on a clk edge where show_valid (or flash_req)
  // and show_ready are both high; show_ready is high only in IDLE outside reset.
  led_seq_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] leds_q, leds_d;
  logic [DATA_WIDTH-1:0] item_q, item_d;
  logic                  win_q, win_d;
  logic [PW-1:0]         pairs_q, pairs_d;
  logic                  done_q, done_d;
  logic                  timer_load;
  logic [CW-1:0]         timer_val;
  logic                  timer_zero;

  cycle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (busy),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    leds_d     = leds_q;
    item_d     = item_q;
    win_d      = win_q;
    pairs_d    = pairs_q;
    done_d     = 1'b0;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (flash_req) begin
          win_d      = flash_win;
          pairs_d    = PW'(FLASH_COUNT);
          state_d    = ST_FLASH_ON;
          leds_d     = flash_win ? '1 : DEFEAT_LEDS;
          timer_load = 1'b1;
          timer_val  = CW'(FLASH_CYCLES - 1);
        end else if (show_valid) begin
          item_d     = item;
          state_d    = ST_SHOW_ON;
          leds_d     = item;
          timer_load = 1'b1;
          timer_val  = speed ? CW'(ON_CYCLES_FAST - 1) : CW'(ON_CYCLES_SLOW - 1);
        end
      end
      ST_SHOW_ON: begin
        leds_d = item_q;
        if (timer_zero) begin
          state_d    = ST_SHOW_GAP;
          leds_d     = '0;
          timer_load = 1'b1;
          timer_val  = CW'(GAP_CYCLES - 1);
        end
      end
      ST_SHOW_GAP: begin
        if (timer_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_FLASH_ON: begin
        if (timer_zero) begin
          state_d    = ST_FLASH_OFF;
          leds_d     = '0;
          timer_load = 1'b1;
          timer_val  = CW'(FLASH_CYCLES - 1);
        end
      end
      ST_FLASH_OFF: begin
        if (timer_zero) begin
          pairs_d = pairs_q - PW'(1);
          if (pairs_q == PW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_FLASH_ON;
            leds_d     = win_q ? '1 : DEFEAT_LEDS;
            timer_load = 1'b1;
            timer_val  = CW'(FLASH_CYCLES - 1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        leds_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      leds_q  <= '0;
      item_q  <= '0;
      win_q   <= 1'b0;
      pairs_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      item_q  <= item_d;
      win_q   <= win_d;
      pairs_q <= pairs_d;
      done_q  <= done_d;
    end
  end

  assign show_ready = (state_q == ST_IDLE) && !rst;
  assign busy       = (state_q != ST_IDLE);
  assign leds       = leds_q;
  assign done       = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed plus randomized bench for led_sequencer: each operation expands into
// an expected per-cycle LED timeline that is replayed against the DUT.
module tb_led_sequencer;

  localparam int W    = 4;
  localparam int SLOW = 8;
  localparam int FAST = 4;
  localparam int GAP  = 2;
  localparam int FL   = 3;
  localparam int FC   = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         show_valid;
  logic         show_ready;
  logic [W-1:0] item;
  logic         speed;
  logic         flash_req;
  logic         flash_win;
  logic [W-1:0] leds;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  led_sequencer #(
    .DATA_WIDTH     (W),
    .ON_CYCLES_SLOW (SLOW),
    .ON_CYCLES_FAST (FAST),
    .GAP_CYCLES     (GAP),
    .FLASH_CYCLES   (FL),
    .FLASH_COUNT    (FC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .show_valid (show_valid),
    .show_ready (show_ready),
    .item       (item),
    .speed      (speed),
    .flash_req  (flash_req),
    .flash_win  (flash_win),
    .leds       (leds),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [W-1:0] defeat_ref();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ((i % 2) == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Replays exp_q one cycle per entry (DUT busy), then checks the done cycle.
  task automatic drain(input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_leds"}, 32'(leds), 32'(e));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      chk({tag, "_ready_busy"}, 32'(show_ready), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ready_done"}, 32'(show_ready), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_leds_done"}, 32'(leds), 32'd0);
  endtask

  // Presents a show request in the current (idle) cycle; optionally keeps
  // show_valid high with the next item so it is taken in the done cycle.
  task automatic show_op(input string tag, input logic [W-1:0] it, input logic sp,
                         input logic keep, input logic [W-1:0] nit, input logic nsp);
    show_valid = 1'b1;
    item       = it;
    speed      = sp;
    chk({tag, "_ready_accept"}, 32'(show_ready), 32'd1);
    @(negedge clk);
    if (keep) begin
      item  = nit;
      speed = nsp;
    end else begin
      show_valid = 1'b0;
      item       = W'($urandom);
      speed      = 1'($urandom);
    end
    flash_win = 1'($urandom);
    exp_q.delete();
    repeat (sp ? FAST : SLOW) exp_q.push_back(it);
    repeat (GAP) exp_q.push_back('0);
    drain(tag);
  endtask

  task automatic flash_op(input string tag, input logic win, input logic keep_show);
    flash_req = 1'b1;
    flash_win = win;
    chk({tag, "_ready_accept"}, 32'(show_ready), 32'd1);
    @(negedge clk);
    flash_req = 1'b0;
    flash_win = ~win;
    if (!keep_show) show_valid = 1'b0;
    exp_q.delete();
    repeat (FC) begin
      repeat (FL) exp_q.push_back(win ? '1 : defeat_ref());
      repeat (FL) exp_q.push_back('0);
    end
    drain(tag);
  endtask

  task automatic idle_after(input string tag);
    show_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_ready"}, 32'(show_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] rit;
    logic         rsp;
    rst        = 1'b1;
    show_valid = 1'b0;
    item       = '0;
    speed      = 1'b0;
    flash_req  = 1'b0;
    flash_win  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(show_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(show_ready), 32'd1);

    // Slow item, single-cycle valid.
    show_op("s1", 4'b0010, 1'b0, 1'b0, '0, 1'b0);
    idle_after("s1");

    // Fast item with a second item held valid and taken in the done cycle.
    show_op("s2a", 4'b1000, 1'b1, 1'b1, 4'b0001, 1'b1);
    show_op("s2b", 4'b0001, 1'b1, 1'b0, '0, 1'b0);
    idle_after("s2");

    // Flash beats a simultaneous show; the show follows in the done cycle.
    show_valid = 1'b1;
    item       = 4'b0110;
    speed      = 1'b1;
    flash_op("s3", 1'b1, 1'b1);
    show_op("s3_show", 4'b0110, 1'b1, 1'b0, '0, 1'b0);
    idle_after("s3");

    // Defeat flash.
    flash_op("s4", 1'b0, 1'b0);
    idle_after("s4");

    // Reset in the middle of SHOW_ON.
    show_valid = 1'b1;
    item       = 4'b1011;
    speed      = 1'b0;
    @(negedge clk);
    show_valid = 1'b0;
    repeat (3) begin
      chk("s5_leds_on", 32'(leds), 32'b1011);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("s5_rst_leds", 32'(leds), 32'd0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_done", 32'(done), 32'd0);
    chk("s5_rst_ready", 32'(show_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("s5_ready_after", 32'(show_ready), 32'd1);
    repeat (15) begin
      chk("s5_no_late_done", 32'(done), 32'd0);
      chk("s5_no_late_busy", 32'(busy), 32'd0);
      chk("s5_leds_dark", 32'(leds), 32'd0);
      @(negedge clk);
    end

    // Blank item keeps full timing.
    show_op("s6", 4'b0000, 1'b0, 1'b0, '0, 1'b0);
    idle_after("s6");

    // Randomized mix of shows, back-to-back shows and flashes.
    for (int k = 0; k < 10; k++) begin
      rit = W'($urandom);
      rsp = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: begin
          show_op("rnd_show", rit, rsp, 1'b0, '0, 1'b0);
        end
        1: begin
          show_op("rnd_b2b_a", rit, rsp, 1'b1, ~rit, ~rsp);
          show_op("rnd_b2b_b", ~rit, ~rsp, 1'b0, '0, 1'b0);
        end
        default: begin
          flash_op("rnd_flash", 1'($urandom_range(0, 1)), 1'b0);
        end
      endcase
      idle_after("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
